hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard/stall sequencer driving the control-unit bubble mux select, PC write enable and IF/ID register enables.
//  Detects load-use hazards (ID vs EX), taken-branch flushes and data-memory wait states.
//  Sequences multi-cycle stalls/flushes with an FSM. Keeps saturating stall/flush performance counters.
// PARAMETERS
//  REG_ADDR_W      4   register address width
//  LOAD_USE_STALL  1   bubble cycles per load-use hazard (legal 1..3)
//  FLUSH_CYCLES    1   IF/ID flush cycles per taken branch (legal 1..3)
//  CNT_W           16  width of each performance counter
// PORTS
//  clk              in   1           single clock, rising edge
//  rst_n            in   1           asynchronous, active-low reset
//  id_rn_addr       in   REG_ADDR_W  ID-stage Rn source
//  id_rn_used       in   1           ID instruction reads Rn
//  id_rm_addr       in   REG_ADDR_W  ID-stage Rm source
//  id_rm_used       in   1           ID instruction reads Rm
//  ex_rd_addr       in   REG_ADDR_W  EX-stage destination
//  ex_reg_write     in   1           EX instruction writes Rd
//  ex_mem_to_reg    in   1           EX instruction is a load
//  branch_taken_ex  in   1           branch resolved taken in EX
//  mem_busy         in   1           data memory not ready; freeze pipeline
//  cnt_clr          in   1           synchronous clear of both counters
//  pc_write_en      out  1           PC register load enable
//  if_id_write_en   out  1           IF/ID register load enable
//  if_id_flush      out  1           IF/ID register clear (NOP)
//  cu_mux_select    out  1           1 = pass control signals, 0 = insert bubble
//  pipe_freeze      out  1           hold ID/EX, EX/MEM, MEM/WB registers
//  stall_cnt        out  CNT_W       saturating count of load-use bubble cycles
//  flush_cnt        out  CNT_W       saturating count of taken-branch events
// BEHAVIOUR
//  States: INIT, RUN, LU_STALL, FLUSH, FREEZE. Outputs are Mealy (state + current inputs); no added latency.
//  Hazard: lu_haz = ex_mem_to_reg & ex_reg_write & ((id_rn_used & id_rn_addr==ex_rd_addr) | (id_rm_used & id_rm_addr==ex_rd_addr)).
//  Reset (rst_n=0) takes effect immediately, asynchronously: state=INIT, remaining-cycle counter=0, stall_cnt=flush_cnt=0.
//  INIT: pc_write_en=0, if_id_write_en=0, if_id_flush=0, cu_mux_select=0, pipe_freeze=0.
//    Goes unconditionally to RUN on the first clock edge after rst_n rises.
//  Priority in RUN: mem_busy > branch_taken_ex > lu_haz.
//  RUN, no event: pc_we=1, if_id_we=1, flush=0, sel=1, freeze=0.
//  RUN + mem_busy: freeze=1, pc_we=0, if_id_we=0, sel=1, flush=0. Next state is FREEZE with resume=RUN.
//  RUN + branch_taken_ex: pc_we=1, if_id_we=0, flush=1, sel=0, flush_cnt+1.
//    Next state is FLUSH with rem=FLUSH_CYCLES-1 if FLUSH_CYCLES>1; otherwise next state is RUN.
//  RUN + lu_haz: pc_we=0, if_id_we=0, sel=0, flush=0, stall_cnt+1.
//    Next state is LU_STALL with rem=LOAD_USE_STALL-1 if LOAD_USE_STALL>1; otherwise next state is RUN.
//  LU_STALL: same outputs as the lu_haz cycle; stall_cnt+1 each cycle; rem decrements; returns to RUN when rem reaches 0.
//    branch_taken_ex here pre-empts: treat exactly as RUN+branch, and drop the remaining stall.
//  FLUSH: pc_we=1, if_id_we=0, flush=1, sel=0; rem decrements; returns to RUN at rem=0. A new branch_taken_ex restarts rem.
//  From any state except INIT, mem_busy=1 forces FREEZE outputs and saves the resume state.
//    rem is held and counters do not increment while frozen.
//    When mem_busy falls, the next edge resumes the saved state with rem unchanged.
//  Counters saturate at all-ones. cnt_clr wins over an increment in the same cycle.
//  Address compare uses full REG_ADDR_W; no register is excluded.
//  Parameter values outside 1..3 are a configuration error: assert in simulation.
// STRUCTURE
//  Shared package cpu_ctrl_pkg: hz_state_t enum {INIT,RUN,LU_STALL,FLUSH,FREEZE}, REG_ADDR_W default.
//  Instantiate sub-module sat_counter (params W; ports clk, rst_n, inc, clr, q) twice: stall_cnt and flush_cnt.
//  FSM, rem counter (2 bits), resume-state register and hazard compare stay in this module.
// TESTING
//  1 Reset: rst_n=0 mid-LU_STALL -> all enables 0, sel=0, counters 0. Release -> one INIT cycle, then RUN outputs 1/1/0/1/0.
//  2 Load-use, LOAD_USE_STALL=2: ex_rd=3, load=1, id_rn=3, used=1 -> 2 cycles pc_we=0, sel=0; stall_cnt=2; RUN on 3rd.
//  3 No hazard: same as 2 but id_rn_used=0, or ex_reg_write=0 -> no stall, stall_cnt=0.
//  4 Branch, FLUSH_CYCLES=2: branch_taken_ex pulse -> 2 cycles flush=1, sel=0, pc_we=1; flush_cnt=1.
//  5 Simultaneous: mem_busy=1, branch, and lu_haz in the same cycle -> freeze only.
//    Drop mem_busy with branch still 1 -> flush sequence follows.
//  6 Freeze mid-stall plus saturation: mem_busy for 3 cycles during LU_STALL -> rem and stall_cnt held; resume completes.
//    Preload CNT_W=4 to 15 -> stays at 15; cnt_clr together with an increment -> 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and defaults for the pipeline control slice
// Contents:
//   hz_state_t      hazard/stall sequencer state encoding
//   DEF_REG_ADDR_W  default register-address width
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        RUN      = 3'd1,
        LU_STALL = 3'd2,
        FLUSH    = 3'd3,
        FREEZE   = 3'd4
    } hz_state_t;

    localparam int DEF_REG_ADDR_W = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   inc    in   add one unless already all-ones
//   clr    in   synchronous clear, wins over inc
//   q      out  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch-flush / memory-wait stall sequencer
// Ports:
//   clk, rst_n                    clock (rising) and asynchronous active-low reset
//   id_rn_addr/used, id_rm_addr/used   ID-stage source registers
//   ex_rd_addr, ex_reg_write, ex_mem_to_reg   EX-stage destination / load flag
//   branch_taken_ex               branch resolved taken in EX
//   mem_busy                      data memory wait; freezes the pipeline
//   cnt_clr                       synchronous clear of both performance counters
//   pc_write_en, if_id_write_en, if_id_flush, cu_mux_select, pipe_freeze   pipeline controls (Mealy)
//   stall_cnt, flush_cnt          saturating load-use bubble / taken-branch counts
module hazard_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rn_addr,
    input  logic                  id_rn_used,
    input  logic [REG_ADDR_W-1:0] id_rm_addr,
    input  logic                  id_rm_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  branch_taken_ex,
    input  logic                  mem_busy,
    input  logic                  cnt_clr,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  cu_mux_select,
    output logic                  pipe_freeze,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Cycles still owed after the first stall/flush cycle.
    localparam logic [1:0] LU_REM = 2'(LOAD_USE_STALL - 1);
    localparam logic [1:0] FL_REM = 2'(FLUSH_CYCLES - 1);

    hz_state_t  state_q, state_d;
    hz_state_t  resume_q, resume_d;
    hz_state_t  eff_state;
    logic [1:0] rem_q, rem_d;
    logic       lu_haz;
    logic       stall_inc;
    logic       flush_inc;

    assign lu_haz = ex_mem_to_reg && ex_reg_write &&
                    ((id_rn_used && (id_rn_addr == ex_rd_addr)) ||
                     (id_rm_used && (id_rm_addr == ex_rd_addr)));

    // While frozen the sequencer behaves as the saved state once mem_busy
    // drops, so the release cycle already does useful work (no extra bubble).
    assign eff_state = (state_q == FREEZE) ? resume_q : state_q;

    always_comb begin
        state_d        = state_q;
        resume_d       = resume_q;
        rem_d          = rem_q;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b0;
        cu_mux_select  = 1'b0;
        pipe_freeze    = 1'b0;

        if (state_q == INIT) begin
            state_d = RUN;
        end else if (mem_busy) begin
            // Everything holds: rem, counters and the state we will return to.
            pipe_freeze   = 1'b1;
            cu_mux_select = 1'b1;
            resume_d      = eff_state;
            state_d       = FREEZE;
        end else if (branch_taken_ex &&
                     ((eff_state == RUN) || (eff_state == LU_STALL) || (eff_state == FLUSH))) begin
            // A taken branch pre-empts any stall and restarts any flush.
            pc_write_en = 1'b1;
            if_id_flush = 1'b1;
            flush_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                rem_d   = FL_REM;
            end else begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        end else begin
            case (eff_state)
                RUN: begin
                    if (lu_haz) begin
                        stall_inc = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            state_d = LU_STALL;
                            rem_d   = LU_REM;
                        end else begin
                            state_d = RUN;
                            rem_d   = 2'd0;
                        end
                    end else begin
                        pc_write_en    = 1'b1;
                        if_id_write_en = 1'b1;
                        cu_mux_select  = 1'b1;
                        state_d        = RUN;
                    end
                end
                LU_STALL: begin
                    stall_inc = 1'b1;
                    rem_d     = rem_q - 2'd1;
                    state_d   = (rem_q == 2'd1) ? RUN : LU_STALL;
                end
                FLUSH: begin
                    pc_write_en = 1'b1;
                    if_id_flush = 1'b1;
                    rem_d       = rem_q - 2'd1;
                    state_d     = (rem_q == 2'd1) ? RUN : FLUSH;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            resume_q <= RUN;
            rem_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            rem_q    <= rem_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (cnt_clr),
        .q     (flush_cnt)
    );

    a_lu_range : assert property (@(posedge clk)
        (LOAD_USE_STALL >= 1) && (LOAD_USE_STALL <= 3));
    a_fl_range : assert property (@(posedge clk)
        (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 3));

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int AW   = 4;
    localparam int LU   = 2;
    localparam int FL   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rn_addr, id_rm_addr, ex_rd_addr;
    logic          id_rn_used, id_rm_used, ex_reg_write, ex_mem_to_reg;
    logic          branch_taken_ex, mem_busy, cnt_clr;
    logic          pc_write_en, if_id_write_en, if_id_flush, cu_mux_select, pipe_freeze;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .REG_ADDR_W     (AW),
        .LOAD_USE_STALL (LU),
        .FLUSH_CYCLES   (FL),
        .CNT_W          (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rn_addr      (id_rn_addr),
        .id_rn_used      (id_rn_used),
        .id_rm_addr      (id_rm_addr),
        .id_rm_used      (id_rm_used),
        .ex_rd_addr      (ex_rd_addr),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .branch_taken_ex (branch_taken_ex),
        .mem_busy        (mem_busy),
        .cnt_clr         (cnt_clr),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .cu_mux_select   (cu_mux_select),
        .pipe_freeze     (pipe_freeze),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bubble/flush cycles still owed, plus event totals.
    bit m_init;
    int m_stall_left, m_flush_left, m_stall_cnt, m_flush_cnt;

    task automatic model_reset();
        m_init       = 1'b1;
        m_stall_left = 0;
        m_flush_left = 0;
        m_stall_cnt  = 0;
        m_flush_cnt  = 0;
    endtask

    task automatic set_idle();
        id_rn_addr = 4'd1; id_rn_used = 1'b0;
        id_rm_addr = 4'd2; id_rm_used = 1'b0;
        ex_rd_addr = 4'd9; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
        branch_taken_ex = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic set_hazard();
        set_idle();
        ex_rd_addr = 4'd3; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1;
        id_rn_addr = 4'd3; id_rn_used = 1'b1;
        id_rm_addr = 4'd5; id_rm_used = 1'b1;
    endtask

    // Called just after a rising edge with inputs set; checks one cycle.
    // Output vector order: pc_we, if_id_we, flush, sel, freeze.
    task automatic step(input string tag);
        logic [4:0] exp_v, got_v;
        bit lu, inc_s, inc_f, n_init;
        int n_sl, n_fl;
        inc_s = 0; inc_f = 0;
        lu = ex_mem_to_reg && ex_reg_write &&
             ((id_rn_used && id_rn_addr == ex_rd_addr) || (id_rm_used && id_rm_addr == ex_rd_addr));
        n_init = m_init; n_sl = m_stall_left; n_fl = m_flush_left;
        if (m_init) begin
            exp_v = 5'b00000; n_init = 0;
        end else if (mem_busy) begin
            exp_v = 5'b00011;
        end else if (branch_taken_ex) begin
            exp_v = 5'b10100; inc_f = 1; n_fl = FL - 1; n_sl = 0;
        end else if (m_flush_left > 0) begin
            exp_v = 5'b10100; n_fl = m_flush_left - 1;
        end else if (m_stall_left > 0) begin
            exp_v = 5'b00000; inc_s = 1; n_sl = m_stall_left - 1;
        end else if (lu) begin
            exp_v = 5'b00000; inc_s = 1; n_sl = LU - 1;
        end else begin
            exp_v = 5'b11010;
        end
        @(negedge clk);
        got_v = {pc_write_en, if_id_write_en, if_id_flush, cu_mux_select, pipe_freeze};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s ctrl: got %b expected %b", tag, got_v, exp_v);
        end
        n_cmp++;
        if (stall_cnt !== CW'(m_stall_cnt)) begin
            n_err++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, m_stall_cnt);
        end
        n_cmp++;
        if (flush_cnt !== CW'(m_flush_cnt)) begin
            n_err++;
            $display("FAIL %s flush_cnt: got %0d expected %0d", tag, flush_cnt, m_flush_cnt);
        end
        @(posedge clk);
        m_init = n_init; m_stall_left = n_sl; m_flush_left = n_fl;
        if (cnt_clr) begin
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (inc_s && m_stall_cnt < CMAX) m_stall_cnt++;
            if (inc_f && m_flush_cnt < CMAX) m_flush_cnt++;
        end
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [CW-1:0] got, input int expv);
        n_cmp++;
        if (got !== CW'(expv)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic clear_counters();
        set_idle();
        cnt_clr = 1'b1;
        step("clr");
        cnt_clr = 1'b0;
    endtask

    task automatic check_in_reset(input string tag);
        n_cmp++;
        if ({pc_write_en, if_id_write_en, if_id_flush, cu_mux_select, pipe_freeze, stall_cnt, flush_cnt}
            !== {5'b00000, {CW{1'b0}}, {CW{1'b0}}}) begin
            n_err++;
            $display("FAIL %s: ctrl %b%b%b%b%b cnt %0d/%0d expected all zero", tag,
                     pc_write_en, if_id_write_en, if_id_flush, cu_mux_select, pipe_freeze,
                     stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_in_reset("reset_hold");
        rst_n = 1'b1;
        step("init_cycle");
        step("first_run");
    endtask

    task automatic test_load_use();
        clear_counters();
        set_hazard();
        step("lu_c1");
        set_idle();
        step("lu_c2");
        step("lu_run");
        check_cnt("lu_stall_cnt", stall_cnt, 2);
    endtask

    task automatic test_no_hazard();
        clear_counters();
        set_hazard(); id_rn_used = 1'b0;
        step("nh_rn_unused");
        set_hazard(); ex_reg_write = 1'b0;
        step("nh_no_write");
        set_hazard(); ex_mem_to_reg = 1'b0;
        step("nh_not_load");
        set_idle();
        step("nh_idle");
        check_cnt("nh_stall_cnt", stall_cnt, 0);
        set_hazard(); id_rn_used = 1'b0; id_rm_addr = 4'd3;
        step("rm_hazard");
        set_idle();
        step("rm_c2");
        step("rm_run");
    endtask

    task automatic test_branch();
        clear_counters();
        branch_taken_ex = 1'b1;
        step("br_c1");
        branch_taken_ex = 1'b0;
        step("br_c2");
        step("br_run");
        check_cnt("br_flush_cnt", flush_cnt, 1);
        set_hazard();
        step("br_pre_lu");
        branch_taken_ex = 1'b1;
        step("br_preempt");
        set_idle();
        step("br_pre_c2");
        step("br_pre_run");
    endtask

    task automatic test_simultaneous();
        clear_counters();
        set_hazard();
        branch_taken_ex = 1'b1;
        mem_busy = 1'b1;
        step("sim_frz1");
        step("sim_frz2");
        mem_busy = 1'b0;
        step("sim_br");
        set_idle();
        step("sim_fl2");
        step("sim_run");
        check_cnt("sim_flush_cnt", flush_cnt, 1);
        check_cnt("sim_stall_cnt", stall_cnt, 0);
    endtask

    task automatic test_freeze_mid_stall();
        clear_counters();
        set_hazard();
        step("fz_lu1");
        set_idle();
        mem_busy = 1'b1;
        repeat (3) step("fz_hold");
        check_cnt("fz_held_cnt", stall_cnt, 1);
        mem_busy = 1'b0;
        step("fz_resume");
        step("fz_run");
        check_cnt("fz_final_cnt", stall_cnt, 2);
    endtask

    task automatic test_saturation();
        clear_counters();
        set_hazard();
        repeat (20) step("sat");
        check_cnt("sat_stall_max", stall_cnt, CMAX);
        cnt_clr = 1'b1;
        step("sat_clr");
        cnt_clr = 1'b0;
        check_cnt("sat_clr_wins", stall_cnt, 0);
        set_idle();
        step("sat_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            id_rn_addr      = AW'($urandom_range(0, 3));
            id_rm_addr      = AW'($urandom_range(0, 3));
            ex_rd_addr      = AW'($urandom_range(0, 3));
            id_rn_used      = ($urandom_range(0, 9) < 7);
            id_rm_used      = ($urandom_range(0, 9) < 5);
            ex_reg_write    = ($urandom_range(0, 9) < 7);
            ex_mem_to_reg   = ($urandom_range(0, 9) < 4);
            branch_taken_ex = ($urandom_range(0, 9) < 1);
            mem_busy        = ($urandom_range(0, 99) < 15);
            cnt_clr         = ($urandom_range(0, 99) < 2);
            step("rand");
        end
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        set_hazard();
        step("rm_enter_lu");
        #2;
        rst_n = 1'b0;
        #1;
        check_in_reset("reset_mid_stall");
        model_reset();
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rms_init");
        step("rms_run");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_simultaneous();
        test_freeze_mid_stall();
        test_saturation();
        test_random();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
